// File: rtl/dffsrn_pipe_pkg.sv
// Shared constants and helpers for the dffsrn_pipe elastic register pipeline.
package dffsrn_pipe_pkg;

    localparam logic DFLT_SET_BIT = 1'b1;

    // Counter width able to hold 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dffsrn_pipe_stage.sv
// One pipeline stage (data + valid) on negedge clkn_i; 1-edge load latency.
// No backpressure of its own: load/advance decisions come from the parent's ready chain.
module dffsrn_pipe_stage
    import dffsrn_pipe_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] SET_VAL    = {WIDTH{DFLT_SET_BIT}},
    parameter bit               PRESET_DAT = 1'b0
) (
    input  logic             clkn_i,
    input  logic             rn_i,
    input  logic             sn_i,
    input  logic             load_i,
    input  logic             adv_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             vld_o
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             vld_d, vld_q;

    // Preset beats load; an advancing stage with no refill keeps its stale data.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (!sn_i) begin
            vld_d = 1'b0;
            if (PRESET_DAT) begin
                data_d = SET_VAL;
            end
        end else if (load_i) begin
            data_d = data_i;
            vld_d  = 1'b1;
        end else if (adv_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(negedge clkn_i or negedge rn_i) begin
        if (!rn_i) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign data_o = data_q;
    assign vld_o  = vld_q;

endmodule

// File: rtl/dffsrn_pipe.sv
// WIDTH x DEPTH elastic pipeline on negedge CLKN; DEPTH edges empty-pipe latency, bubbles collapse.
// Combinational ready chain from OUT_READY; optional OCC port with DFFSRN_PIPE_OCC_EN.
module dffsrn_pipe
    import dffsrn_pipe_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{DFLT_SET_BIT}}
) (
    input  logic             CLKN,
    input  logic             RN,
    input  logic             SN,
    input  logic [WIDTH-1:0] D,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             OUT_VALID,
    input  logic             OUT_READY
`ifdef DFFSRN_PIPE_OCC_EN
    ,
    output logic [occ_w(DEPTH)-1:0] OCC
`endif
);

    logic [WIDTH-1:0] stg_dat [DEPTH];
    logic [DEPTH-1:0] stg_vld;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] free;
    logic             push;
    logic             pop;

    // Walk from the output stage back so each stage sees its successor's freedom.
    always_comb begin
        adv          = '0;
        free         = '0;
        adv[DEPTH-1]  = stg_vld[DEPTH-1] & OUT_READY;
        free[DEPTH-1] = ~stg_vld[DEPTH-1] | adv[DEPTH-1];
        for (int k = DEPTH - 2; k >= 0; k--) begin
            adv[k]  = stg_vld[k] & free[k+1];
            free[k] = ~stg_vld[k] | adv[k];
        end
    end

    assign IN_READY = free[0] & RN;
    assign push     = IN_VALID & IN_READY;
    assign pop      = adv[DEPTH-1];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             ld;
        logic [WIDTH-1:0] din;

        if (k == 0) begin : g_in
            assign ld  = push;
            assign din = D;
        end else begin : g_mid
            assign ld  = adv[k-1];
            assign din = stg_dat[k-1];
        end

        dffsrn_pipe_stage #(
            .WIDTH      (WIDTH),
            .SET_VAL    (SET_VAL),
            .PRESET_DAT (k == DEPTH - 1)
        ) u_stage (
            .clkn_i (CLKN),
            .rn_i   (RN),
            .sn_i   (SN),
            .load_i (ld),
            .adv_i  (adv[k]),
            .data_i (din),
            .data_o (stg_dat[k]),
            .vld_o  (stg_vld[k])
        );
    end

    assign Q         = stg_dat[DEPTH-1];
    assign QN        = ~stg_dat[DEPTH-1];
    assign OUT_VALID = stg_vld[DEPTH-1];

`ifdef DFFSRN_PIPE_OCC_EN
    localparam int OCC_W = occ_w(DEPTH);

    logic [OCC_W-1:0] occ_d, occ_q;

    always_comb begin
        occ_d = occ_q;
        if (!SN) begin
            occ_d = '0;
        end else if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(negedge CLKN or negedge RN) begin
        if (!RN) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign OCC = occ_q;
`endif

endmodule
